regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
Shares the single register-file write port (IN / INADDRESS / WRITE) between two writeback sources: ALU result (ALU) and data-memory load (MEM).
- Each source hands over {address, data} through a valid/ready handshake into a one-entry holding slot.
- The arbiter drains the slots into a registered write stage that drives the register file.
- Fair round-robin, with age ordering enforced when both pending writes target the same register.

Parameters:
DATA_W, 8, register data width
ADDR_W, 3, register address width (8 registers)

Ports:
CLK  input  1  system clock; all state changes on posedge
RESET  input  1  asynchronous, active-high reset
ALU_VALID  input  1  ALU writeback request
ALU_ADDR  input  ADDR_W  ALU destination register
ALU_DATA  input  DATA_W  ALU result
ALU_READY  output  1  ALU slot can accept this cycle
MEM_VALID  input  1  load writeback request
MEM_ADDR  input  ADDR_W  load destination register
MEM_DATA  input  DATA_W  load data
MEM_READY  output  1  MEM slot can accept this cycle
RF_IN  output  DATA_W  to register file IN
RF_INADDRESS  output  ADDR_W  to register file INADDRESS
RF_WRITE  output  1  to register file WRITE
BUSY  output  1  any slot full or RF_WRITE high

Behaviour:
- Reset (asynchronous, RESET=1): clears both slots, RF_WRITE=0, RF_IN=0, RF_INADDRESS=0, LAST=MEM. Consequence: ALU wins the first conflict. ALU_READY=MEM_READY=1 once RESET=0.
- Reset mid-operation: pending and in-flight writes are dropped, not replayed.
- Slot state per source: FULL bit, ADDR, DATA, OLDER bit.
- Transfer: a handshake completes at a posedge when VALID & READY.
- READY = ~FULL | GRANT(this source). GRANT is computed only from slot state and LAST, never from VALID, so there is no combinational loop.
- Grant rule, evaluated each cycle:
  - Neither slot full: no grant.
  - One slot full: grant it.
  - Both full, equal ADDR: grant the slot with OLDER=1.
  - Both full, different ADDR: grant the source != LAST.
- Granted posedge:
  - Output register loads the slot's ADDR/DATA and sets RF_WRITE=1.
  - The slot clears, or refills if its source handshakes on the same edge.
  - LAST becomes the winner.
- No grant: RF_WRITE=0. RF_IN and RF_INADDRESS hold their last values.
- Latency: captured at edge N → RF_WRITE high from edge N+1 → register file samples at edge N+2.
- Throughput: one write per cycle combined. A single source streams at one per cycle.
- Age:
  - A slot captured while the other slot is full gets OLDER=0, and the other slot gets OLDER=1.
  - Both captured on the same edge: ALU gets OLDER=1.
  - A slot captured while the other is empty gets OLDER=1.
- Ordering guarantee: for the same destination, writes reach RF_* in acceptance order.
- Same-address back-to-back writes are both issued (no coalescing).
- Holding VALID with READY=0 is legal. The source must keep ADDR/DATA stable until accepted.

Optional Feature:
RF_BYPASS_EN
- Defined: adds input RD_ADDR (ADDR_W) and outputs BYP_HIT (1) and BYP_DATA (DATA_W), all combinational.
- BYP_HIT=1 when RD_ADDR matches a full slot or the output register with RF_WRITE=1.
- BYP_DATA priority: younger full slot, then older full slot, then output register.
- BYP_HIT=0 and BYP_DATA=0 in reset.
- Undefined: the ports are absent and there is no matching logic.

Decomposition:
- Shared package regfile_pkg holds:
  - DATA_W=8 and ADDR_W=3 constants.
  - Source enum SRC_ALU=0, SRC_MEM=1, used for LAST.
  - Writeback request struct {addr, data}.
- Sub-module wb_slot: the one-entry holding register (FULL/ADDR/DATA, accept/drain), instantiated twice. Age and grant logic stay in the top.

Test Plan:
1. Reset: RESET pulsed mid-cycle with both slots full → RF_WRITE=0 and BUSY=0 immediately; the pending writes never appear on RF_*.
2. Single source latency: ALU_VALID with addr 3, data 8'h2A, accepted at edge N → RF_WRITE=1, RF_INADDRESS=3, RF_IN=8'h2A during N+1..N+2; the register file reads 8'h2A afterwards.
3. Conflict round-robin: both sources valid every cycle, ALU addr 1, MEM addr 2, after reset → RF_INADDRESS sequence 1, 2, 1, 2, …; each READY pulses every other cycle.
4. Same-address ordering: MEM (addr 5, 8'h11) accepted one edge before ALU (addr 5, 8'h22) while LAST=MEM → 8'h11 issued first even though round-robin favours ALU; register 5 ends at 8'h22.
5. Streaming: MEM valid for 4 consecutive cycles, ALU idle → MEM_READY stays 1 and RF_WRITE stays high for 4 consecutive cycles.
6. With RF_BYPASS_EN: MEM slot holds addr 6 = 8'h77, output register holds addr 6 = 8'h10, RD_ADDR=6 → BYP_HIT=1, BYP_DATA=8'h77.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths, source enum and writeback request type
package regfile_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_write_arbiter_wb_slot.sv
// rtl/regfile_write_arbiter_wb_slot.sv - one-entry writeback holding slot (module wb_slot)
module wb_slot #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              valid,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              grant,
  output logic              ready,
  output logic              accept,
  output logic              full,
  output logic [ADDR_W-1:0] slot_addr,
  output logic [DATA_W-1:0] slot_data
);

  // A granted slot drains this edge, so it can take a new entry at the same time.
  assign ready  = ~full | grant;
  assign accept = valid & ready;

  // Capture on handshake, otherwise empty out when the arbiter drains us.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      full      <= 1'b0;
      slot_addr <= '0;
      slot_data <= '0;
    end else if (accept) begin
      full      <= 1'b1;
      slot_addr <= addr;
      slot_data <= data;
    end else if (grant) begin
      full      <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - two-source register-file write arbiter; optional RF_BYPASS_EN adds read bypass ports
module regfile_write_arbiter #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ALU_VALID,
  input  logic [ADDR_W-1:0] ALU_ADDR,
  input  logic [DATA_W-1:0] ALU_DATA,
  output logic              ALU_READY,
  input  logic              MEM_VALID,
  input  logic [ADDR_W-1:0] MEM_ADDR,
  input  logic [DATA_W-1:0] MEM_DATA,
  output logic              MEM_READY,
`ifdef RF_BYPASS_EN
  input  logic [ADDR_W-1:0] RD_ADDR,
  output logic              BYP_HIT,
  output logic [DATA_W-1:0] BYP_DATA,
`endif
  output logic [DATA_W-1:0] RF_IN,
  output logic [ADDR_W-1:0] RF_INADDRESS,
  output logic              RF_WRITE,
  output logic              BUSY
);
  import regfile_pkg::*;

  logic              alu_full, mem_full, alu_accept, mem_accept;
  logic [ADDR_W-1:0] alu_addr, mem_addr;
  logic [DATA_W-1:0] alu_data, mem_data;
  logic              alu_older, mem_older;
  logic              grant_alu, grant_mem;
  src_e              last;

  wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_alu_slot (
    .CLK(CLK), .RESET(RESET), .valid(ALU_VALID), .addr(ALU_ADDR), .data(ALU_DATA),
    .grant(grant_alu), .ready(ALU_READY), .accept(alu_accept), .full(alu_full),
    .slot_addr(alu_addr), .slot_data(alu_data)
  );

  wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem_slot (
    .CLK(CLK), .RESET(RESET), .valid(MEM_VALID), .addr(MEM_ADDR), .data(MEM_DATA),
    .grant(grant_mem), .ready(MEM_READY), .accept(mem_accept), .full(mem_full),
    .slot_addr(mem_addr), .slot_data(mem_data)
  );

  // Grant from slot state and LAST only; age overrides round-robin on a same-register clash.
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (alu_full && mem_full) begin
      if (alu_addr == mem_addr) grant_alu = alu_older;
      else                      grant_alu = (last == SRC_MEM);
      grant_mem = ~grant_alu;
    end else begin
      grant_alu = alu_full;
      grant_mem = mem_full;
    end
  end

  // Age bits: a new entry is younger than one that stays resident; same-edge ties go to ALU.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      alu_older <= 1'b0;
      mem_older <= 1'b0;
    end else if (alu_accept && mem_accept) begin
      alu_older <= 1'b1;
      mem_older <= 1'b0;
    end else if (alu_accept) begin
      if (mem_full && !grant_mem) begin
        alu_older <= 1'b0;
        mem_older <= 1'b1;
      end else begin
        alu_older <= 1'b1;
      end
    end else if (mem_accept) begin
      if (alu_full && !grant_alu) begin
        mem_older <= 1'b0;
        alu_older <= 1'b1;
      end else begin
        mem_older <= 1'b1;
      end
    end
  end

  // Registered write stage; address/data hold when idle, LAST tracks the most recent winner.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      RF_WRITE     <= 1'b0;
      RF_IN        <= '0;
      RF_INADDRESS <= '0;
      last         <= SRC_MEM;
    end else if (grant_alu) begin
      RF_WRITE     <= 1'b1;
      RF_IN        <= alu_data;
      RF_INADDRESS <= alu_addr;
      last         <= SRC_ALU;
    end else if (grant_mem) begin
      RF_WRITE     <= 1'b1;
      RF_IN        <= mem_data;
      RF_INADDRESS <= mem_addr;
      last         <= SRC_MEM;
    end else begin
      RF_WRITE     <= 1'b0;
    end
  end

  assign BUSY = alu_full | mem_full | RF_WRITE;

`ifdef RF_BYPASS_EN
  logic alu_first;
  assign alu_first = alu_full & ~(mem_full & alu_older);

  // Lowest priority written first so later (younger) matches override it.
  always_comb begin
    BYP_HIT  = 1'b0;
    BYP_DATA = '0;
    if (!RESET) begin
      if (RF_WRITE && RF_INADDRESS == RD_ADDR) begin
        BYP_HIT  = 1'b1;
        BYP_DATA = RF_IN;
      end
      if (alu_first) begin
        if (mem_full && mem_addr == RD_ADDR) begin BYP_HIT = 1'b1; BYP_DATA = mem_data; end
        if (alu_full && alu_addr == RD_ADDR) begin BYP_HIT = 1'b1; BYP_DATA = alu_data; end
      end else begin
        if (alu_full && alu_addr == RD_ADDR) begin BYP_HIT = 1'b1; BYP_DATA = alu_data; end
        if (mem_full && mem_addr == RD_ADDR) begin BYP_HIT = 1'b1; BYP_DATA = mem_data; end
      end
    end
  end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;
  import regfile_pkg::*;

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic              ALU_VALID = 1'b0, MEM_VALID = 1'b0;
  logic [ADDR_W-1:0] ALU_ADDR = '0, MEM_ADDR = '0;
  logic [DATA_W-1:0] ALU_DATA = '0, MEM_DATA = '0;
  logic              ALU_READY, MEM_READY;
  logic [DATA_W-1:0] RF_IN;
  logic [ADDR_W-1:0] RF_INADDRESS;
  logic              RF_WRITE, BUSY;
`ifdef RF_BYPASS_EN
  logic [ADDR_W-1:0] RD_ADDR = '0;
  logic              BYP_HIT;
  logic [DATA_W-1:0] BYP_DATA;
`endif

  logic [DATA_W-1:0] rf_model [0:(1<<ADDR_W)-1];
  int n_checks = 0;
  int n_errors = 0;

  regfile_write_arbiter dut (
    .CLK(CLK), .RESET(RESET),
    .ALU_VALID(ALU_VALID), .ALU_ADDR(ALU_ADDR), .ALU_DATA(ALU_DATA), .ALU_READY(ALU_READY),
    .MEM_VALID(MEM_VALID), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA), .MEM_READY(MEM_READY),
`ifdef RF_BYPASS_EN
    .RD_ADDR(RD_ADDR), .BYP_HIT(BYP_HIT), .BYP_DATA(BYP_DATA),
`endif
    .RF_IN(RF_IN), .RF_INADDRESS(RF_INADDRESS), .RF_WRITE(RF_WRITE), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Register file model fed by the write port.
  always @(posedge CLK) if (RF_WRITE) rf_model[RF_INADDRESS] <= RF_IN;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    ALU_VALID = 1'b0;
    MEM_VALID = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    RESET = 1'b1;
    #2;
    RESET = 1'b0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < (1<<ADDR_W); i++) rf_model[i] = '0;

    // Reset values
    #2;
    chk("rst_write", RF_WRITE, 0);
    chk("rst_in", RF_IN, 0);
    chk("rst_addr", RF_INADDRESS, 0);
    chk("rst_busy", BUSY, 0);
    #10 RESET = 1'b0;
    #1;
    chk("rst_alu_ready", ALU_READY, 1);
    chk("rst_mem_ready", MEM_READY, 1);
    tick();

    // Reset mid-operation drops both pending writes
    ALU_VALID = 1; ALU_ADDR = 1; ALU_DATA = 8'h55;
    MEM_VALID = 1; MEM_ADDR = 2; MEM_DATA = 8'h66;
    tick();
    idle();
    chk("pre_rst_busy", BUSY, 1);
    #2 RESET = 1'b1;
    #1;
    chk("midrst_write", RF_WRITE, 0);
    chk("midrst_busy", BUSY, 0);
    #1 RESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("drop_write", RF_WRITE, 0);
    end
    chk("drop_r1", rf_model[1], 0);
    chk("drop_r2", rf_model[2], 0);

    // Single source latency
    do_reset();
    ALU_VALID = 1; ALU_ADDR = 3; ALU_DATA = 8'h2A;
    tick();
    idle();
    chk("lat_n_write", RF_WRITE, 0);
    chk("lat_n_busy", BUSY, 1);
    tick();
    chk("lat_n1_write", RF_WRITE, 1);
    chk("lat_n1_addr", RF_INADDRESS, 3);
    chk("lat_n1_in", RF_IN, 8'h2A);
    tick();
    chk("lat_n2_write", RF_WRITE, 0);
    chk("lat_n2_hold", RF_INADDRESS, 3);
    chk("lat_rf3", rf_model[3], 8'h2A);
    chk("lat_idle_busy", BUSY, 0);

    // Conflict round-robin with held VALID
    do_reset();
    ALU_VALID = 1; ALU_ADDR = 1; ALU_DATA = 8'hA1;
    MEM_VALID = 1; MEM_ADDR = 2; MEM_DATA = 8'hB2;
    for (int i = 0; i < 7; i++) begin
      #1;
      chk("rr_alu_ready", ALU_READY, (i == 0) ? 1 : (i % 2));
      chk("rr_mem_ready", MEM_READY, (i == 0) ? 1 : ((i + 1) % 2));
      tick();
      if (i == 0) chk("rr_first_write", RF_WRITE, 0);
      else begin
        chk("rr_write", RF_WRITE, 1);
        chk("rr_addr", RF_INADDRESS, (i % 2) ? 1 : 2);
      end
    end
    idle();
    for (int i = 0; i < 4; i++) tick();
    chk("rr_drained", BUSY, 0);

    // Same register: MEM accepted one edge before ALU
    do_reset();
    MEM_VALID = 1; MEM_ADDR = 5; MEM_DATA = 8'h11;
    tick();
    idle();
    ALU_VALID = 1; ALU_ADDR = 5; ALU_DATA = 8'h22;
    tick();
    idle();
    chk("ord_first_in", RF_IN, 8'h11);
    tick();
    chk("ord_second_in", RF_IN, 8'h22);
    tick();
    chk("ord_r5", rf_model[5], 8'h22);

    // Same-edge capture, LAST=ALU: age must beat round-robin
    do_reset();
    ALU_VALID = 1; ALU_ADDR = 1; ALU_DATA = 8'h01;
    tick();
    ALU_ADDR = 5; ALU_DATA = 8'h33;
    MEM_VALID = 1; MEM_ADDR = 5; MEM_DATA = 8'h44;
    #1;
    chk("age_alu_ready", ALU_READY, 1);
    chk("age_mem_ready", MEM_READY, 1);
    tick();
    idle();
    chk("age_w1_addr", RF_INADDRESS, 1);
    tick();
    chk("age_w2_in", RF_IN, 8'h33);
    tick();
    chk("age_w3_in", RF_IN, 8'h44);
    chk("age_w3_write", RF_WRITE, 1);
    tick();
    chk("age_r5", rf_model[5], 8'h44);

    // Single-source streaming
    do_reset();
    for (int i = 0; i < 6; i++) begin
      MEM_VALID = (i < 4);
      MEM_ADDR  = ADDR_W'(i);
      MEM_DATA  = DATA_W'(8'h40 + i);
      #1;
      if (i < 4) chk("stream_ready", MEM_READY, 1);
      tick();
      if (i >= 1 && i <= 4) begin
        chk("stream_write", RF_WRITE, 1);
        chk("stream_in", RF_IN, 8'h40 + i - 1);
      end
    end
    chk("stream_end_write", RF_WRITE, 0);

`ifdef RF_BYPASS_EN
    // Bypass: slot entry younger than the output register wins
    do_reset();
    MEM_VALID = 1; MEM_ADDR = 6; MEM_DATA = 8'h10;
    tick();
    MEM_DATA = 8'h77;
    tick();
    idle();
    RD_ADDR = 6;
    #1;
    chk("byp_rf_write", RF_WRITE, 1);
    chk("byp_hit", BYP_HIT, 1);
    chk("byp_data", BYP_DATA, 8'h77);
    RD_ADDR = 2;
    #1;
    chk("byp_miss", BYP_HIT, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
